// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore T-state control unit producing DataPath strobes.
// Fetches via PC/MAR/MDR into IR, decodes ir[31:27], and sequences ALU/HI/LO writes.
module control_sequencer (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  Operator,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Run
);
    typedef enum logic [3:0] {RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT_ST} state_t;
    state_t state, next;
    logic [4:0] opcode;
    logic is_alu, is_md, unused_fields;
    state_t boundary;
    assign opcode = ir[31:27];
    assign unused_fields = ^ir[26:0];
    assign is_alu = opcode >= 5'b00011 && opcode <= 5'b01010;
    assign is_md = opcode == 5'b01111 || opcode == 5'b10000;
    // stop is only honoured on the way back into T0
    assign boundary = stop ? HALT_ST : T0;

    always_ff @(posedge clk or posedge clear)
        if (clear) state <= RESET_ST;
        else state <= next;

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin} = '0;
        {IncPC, Read, Gra, Grb, Grc, Rin, Rout} = '0;
        Operator = 5'b00000;
        Run = state != RESET_ST && state != HALT_ST;
        next = state;
        case (state)
            RESET_ST: next = boundary;
            T0: begin
                {PCout, MARin, IncPC, Zin} = '1;
                next = T1;
            end
            T1: begin
                {Zlowout, PCin, Read, MDRin} = '1;
                next = T2;
            end
            T2: begin
                {MDRout, IRin} = '1;
                next = T3;
            end
            T3: begin
                {Grb, Rout, Yin} = '1;
                next = (is_alu || is_md) ? T4 : opcode == 5'b11001 ? HALT_ST : boundary;
            end
            T4: begin
                {Grc, Rout, Zin} = '1;
                Operator = opcode;
                next = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                LOin = is_md;
                Gra = !is_md;
                Rin = !is_md;
                next = is_md ? T6 : boundary;
            end
            T6: begin
                {Zhighout, HIin} = '1;
                next = boundary;
            end
            HALT_ST: next = HALT_ST;
            default: next = RESET_ST;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction streams checked against a per-phase strobe model.
module tb_control_sequencer;
    logic clk = 1'b1, clear = 1'b0, stop = 1'b0;
    logic [31:0] ir = '0;
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
    logic [4:0] Operator;
    logic [24:0] obs;
    int tests = 0, fails = 0;

    control_sequencer dut (
        .clk(clk), .clear(clear), .ir(ir), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Operator(Operator),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Run(Run)
    );

    always #5 clk = ~clk;

    assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  LOin, HIin, IncPC, Read, Operator, Gra, Grb, Grc, Rin, Rout, Run};

    localparam logic [24:0] S_PCOUT = 25'h1 << 24, S_ZLO = 25'h1 << 23, S_ZHI = 25'h1 << 22;
    localparam logic [24:0] S_MDROUT = 25'h1 << 21, S_MARIN = 25'h1 << 20, S_ZIN = 25'h1 << 19;
    localparam logic [24:0] S_PCIN = 25'h1 << 18, S_MDRIN = 25'h1 << 17, S_IRIN = 25'h1 << 16;
    localparam logic [24:0] S_YIN = 25'h1 << 15, S_LOIN = 25'h1 << 14, S_HIIN = 25'h1 << 13;
    localparam logic [24:0] S_INCPC = 25'h1 << 12, S_READ = 25'h1 << 11;
    localparam logic [24:0] S_GRA = 25'h1 << 5, S_GRB = 25'h1 << 4, S_GRC = 25'h1 << 3;
    localparam logic [24:0] S_RIN = 25'h1 << 2, S_ROUT = 25'h1 << 1, S_RUN = 25'h1;

    function automatic bit is_alu(input logic [4:0] op);
        return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
    endfunction

    function automatic bit is_md(input logic [4:0] op);
        return op == 5'd15 || op == 5'd16;
    endfunction

    function automatic int inst_len(input logic [4:0] op);
        return is_alu(op) ? 6 : is_md(op) ? 7 : 4;
    endfunction

    function automatic logic [24:0] phase_vec(input int i, input logic [4:0] op);
        case (i)
            0: return S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_RUN;
            1: return S_ZLO | S_PCIN | S_READ | S_MDRIN | S_RUN;
            2: return S_MDROUT | S_IRIN | S_RUN;
            3: return S_GRB | S_ROUT | S_YIN | S_RUN;
            4: return S_GRC | S_ROUT | S_ZIN | (25'(op) << 6) | S_RUN;
            5: return is_md(op) ? (S_ZLO | S_LOIN | S_RUN) : (S_ZLO | S_GRA | S_RIN | S_RUN);
            default: return S_ZHI | S_HIIN | S_RUN;
        endcase
    endfunction

    // Called at a falling edge; leaves the DUT in T0 at the next-but-one falling edge.
    task automatic do_clear(input string nm);
        clear = 1'b1;
        #1;
        tests++;
        if (obs !== 25'h0) begin
            fails++;
            $display("FAIL %s clear_async: got %h want 0", nm, obs);
        end
        @(negedge clk);
        tests++;
        if (obs !== 25'h0) begin
            fails++;
            $display("FAIL %s clear_held: got %h want 0", nm, obs);
        end
        clear = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== phase_vec(0, 5'd0)) begin
            fails++;
            $display("FAIL %s restart_t0: got %h want %h", nm, obs, phase_vec(0, 5'd0));
        end
    endtask

    // Runs one instruction from T0; stop_t4 raises stop during T4.
    task automatic exec(input logic [31:0] iv, input bit stop_t4, input string nm);
        logic [4:0] op;
        bit halts;
        op = iv[31:27];
        halts = op == 5'b11001 || stop_t4;
        ir = iv;
        for (int i = 0; i < inst_len(op); i++) begin
            tests++;
            if (obs !== phase_vec(i, op)) begin
                fails++;
                $display("FAIL %s phase%0d ir=%h: got %h want %h", nm, i, iv, obs, phase_vec(i, op));
            end
            if (stop_t4 && i == 4) stop = 1'b1;
            @(negedge clk);
        end
        if (halts) begin
            for (int c = 0; c < 12; c++) begin
                tests++;
                if (obs !== 25'h0) begin
                    fails++;
                    $display("FAIL %s halt_cycle%0d: got %h want 0", nm, c, obs);
                end
                @(negedge clk);
            end
            stop = 1'b0;
            do_clear({nm, "_exit"});
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        do_clear("reset");
    endtask

    task automatic test_directed;
        exec(32'h22920000, 0, "sub");
        exec(32'h79100000, 0, "mul");
        exec(32'h81100000, 0, "div");
        exec(32'hC0000000, 0, "nop");
        exec(32'hF8000000, 0, "undef");
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        for (int n = 0; n < 60; n++) begin
            v = $urandom;
            while (v[31:27] == 5'b11001) v = $urandom;
            exec(v, 0, "random");
        end
    endtask

    task automatic test_halt;
        exec(32'hC8000000, 0, "halt");
    endtask

    task automatic test_stop;
        exec(32'h19100000, 1, "stop_add");
        exec({5'b01111, 27'($urandom)}, 0, "after_stop");
    endtask

    task automatic test_clear_mid;
        ir = 32'h19100000;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (obs !== phase_vec(i, 5'b00011)) begin
                fails++;
                $display("FAIL clear_mid phase%0d: got %h want %h", i, obs, phase_vec(i, 5'b00011));
            end
            if (i < 4) @(negedge clk);
        end
        do_clear("clear_mid");
        exec(32'h19100000, 0, "post_clear_add");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_halt;
        test_stop;
        test_clear_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit that drives the phase-1 DataPath control strobes. It replaces hand-sequenced bench stimulus with a clocked T-state machine. Each pass fetches an instruction through PC/MAR/MDR into IR, decodes the 5-bit opcode, and steps the ALU, register-select, Y, Z and HI/LO strobes to completion. It sits directly upstream of DataPath, takes IR contents back from it, and feeds the select-and-encode logic through Gra/Grb/Grc/Rin/Rout.

## Interface
- No parameters; opcode encodings are fixed by this spec.
- clk  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset; same net as DataPath clear.
- ir  in  32  IR contents from DataPath; opcode = ir[31:27].
- stop  in  1  halt request, sampled only at instruction boundary.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin  out  1 each  register-load strobes.
- IncPC, Read  out  1 each  PC increment in ALU; memory read into MDR.
- Operator  out  5  ALU operation code.
- Gra, Grb, Grc, Rin, Rout  out  1 each  general-register field select and direction.
- Run  out  1  high while executing; low in RESET_ST and HALT_ST.

## Operation
- States: RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT_ST. Outputs are decoded purely from the present state, plus ir in T3–T6. Any strobe not listed for a state is 0.
- RESET_ST: all outputs 0 and Operator=5'b00000.
  - Next state is T0, or HALT_ST if stop=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3: Grb, Rout, Yin.
  - If opcode is nop (11000), next state is T0.
  - If opcode is halt (11001), next state is HALT_ST.
  - Any other undefined opcode behaves as nop.
- T4: Grc, Rout, Zin, Operator=opcode.
- T5 for two-operand ALU ops: Zlowout, Gra, Rin. Next state is T0.
  - Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
- T5 for mul (01111) and div (10000): Zlowout, LOin. Next state is T6.
- T6: Zhighout, HIin. Next state is T0.
- Instruction boundary: every transition into T0 checks stop.
  - stop=1 sends the FSM to HALT_ST instead of T0.
  - stop is ignored in T1–T6.
- HALT_ST: all outputs 0 and Run=0. Only clear exits this state.
- Register fields belong to the encoder, not this block: Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].

## Timing
- One state per clk cycle. Outputs settle combinationally after the state register updates.
- Every strobe is valid for one full cycle, so DataPath loads on the next rising edge.
- Latency from T0 entry to result written:
  - two-operand ALU op: 6 cycles;
  - mul/div: 7 cycles;
  - nop: 4 cycles.
- Opcode is read from ir in T3 and later. IR is loaded at the end of T2, so T3 sees the new instruction.
- clear assertion:
  - forces RESET_ST immediately, without waiting for a clock edge;
  - all outputs go to 0 asynchronously, in any state, including mid-instruction;
  - no partial write completes after clear rises.
- clear release: the first rising edge with clear=0 leaves RESET_ST.
- Operator holds 5'b00000 in every state except T4.
- Read/MDRin high only in T1; IRin high only in T2.

## Test plan
- Reset: assert clear at t=5ns mid-cycle.
  - Required: all strobes 0 and Run=0 before the next edge.
  - Release clear: T0 begins on the first edge, with PCout=MARin=IncPC=Zin=1.
- sub fetch/execute: memory returns 32'h22920000 in T1.
  - T3: Grb=Rout=Yin=1.
  - T4: Grc=Rout=Zin=1, Operator=5'b00100.
  - T5: Zlowout=Gra=Rin=1.
  - The following cycle is T0.
- mul: ir=32'h79100000 (opcode 01111).
  - T5 asserts Zlowout+LOin; T6 asserts Zhighout+HIin.
  - 7 cycles total; Rin never asserted.
- nop and undefined opcode: ir=32'hC0000000 and ir=32'hF8000000 (opcode 11111).
  - Each returns to T0 after T3.
  - Zin, Rin, LOin and HIin stay 0 throughout.
- halt/stop:
  - ir=32'hC8000000 enters HALT_ST after T3, with Run=0 and all strobes 0 for 10+ cycles.
  - Separately, stop=1 raised during T4 of an add has no effect until T5 completes. Next state is HALT_ST, not T0.
- Clear mid-instruction: assert clear during T4 of add (ir=32'h19100000).
  - Zin and Operator drop to 0 immediately.
  - After release, the sequence restarts at T0 with no T5 write pulse observed.
